// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for a shared PicoRV32-style iomem bus.
// One transaction in flight, forced error completion on slave timeout.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic        grant_nx;
  logic        last_grant;
  logic        last_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;

  logic        busy;
  logic        g_valid;
  logic        to_hit;
  logic        done;
  logic [31:0] rdata;

  always_comb begin
    busy    = (state == BUSY);
    g_valid = grant ? m1_valid : m0_valid;
    // s_ready beats the timeout when both land together
    to_hit  = busy & g_valid & ~s_ready &
              (cnt == TO_LAST);
    done    = busy & g_valid & (s_ready | to_hit);
    rdata   = s_ready ? s_rdata : ERR_DATA;
  end

  always_comb begin
    s_valid     = ~reset & busy & g_valid & ~to_hit;
    s_wstrb     = grant ? m1_wstrb : m0_wstrb;
    s_addr      = grant ? m1_addr  : m0_addr;
    s_wdata     = grant ? m1_wdata : m0_wdata;
    m0_ready    = ~reset & done & ~grant;
    m1_ready    = ~reset & done &  grant;
    m0_rdata    = m0_ready ? rdata : 32'h0;
    m1_rdata    = m1_ready ? rdata : 32'h0;
    timeout_err = ~reset & to_hit;
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last_grant;
    cnt_nx   = 16'h0;
    unique case (1'b1)
      (state == IDLE): begin
        if (m0_valid | m1_valid) begin
          state_nx = BUSY;
          grant_nx = (m0_valid & m1_valid) ?
                     ~last_grant : m1_valid;
        end
      end
      (state == BUSY): begin
        if (~g_valid | s_ready | to_hit) begin
          state_nx = IDLE;
          last_nx  = grant;
        end else begin
          cnt_nx = cnt + 16'h1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 16'h0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_nx;
      cnt        <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed corner cases plus randomized traffic for iomem_arbiter,
// checked through a response scoreboard and arbitration model.
module tb_iomem_arbiter;

  localparam int T = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0;
  logic        m0_ready;
  logic [3:0]  m0_wstrb = 4'h0;
  logic [31:0] m0_addr = 32'h0;
  logic [31:0] m0_wdata = 32'h0;
  logic [31:0] m0_rdata;
  logic        m1_valid = 1'b0;
  logic        m1_ready;
  logic [3:0]  m1_wstrb = 4'h0;
  logic [31:0] m1_addr = 32'h0;
  logic [31:0] m1_wdata = 32'h0;
  logic [31:0] m1_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata = 32'h0;
  logic        grant;
  logic        timeout_err;

  iomem_arbiter #(
    .TIMEOUT_CYCLES(T),
    .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready),
    .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   vec = 0;
  int   err = 0;
  logic rnd_stop = 1'b0;
  logic exp_to = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input logic g);
    if (g) m1_valid = 1'b0;
    else   m0_valid = 1'b0;
  endtask

  task automatic txn(input logic g, input int lat,
                     input logic [31:0] rd);
    cyc(); #1;
    chk("grant", 32'(grant), 32'(g));
    chk("s_valid", 32'(s_valid), 1);
    chk("s_addr", s_addr, g ? m1_addr : m0_addr);
    chk("s_wstrb", 32'(s_wstrb),
        32'(g ? m1_wstrb : m0_wstrb));
    chk("s_wdata", s_wdata, g ? m1_wdata : m0_wdata);
    for (int i = 0; i < lat; i++) begin
      chk("early_rdy", 32'({m1_ready, m0_ready}), 0);
      cyc(); #1;
    end
    s_ready = 1'b1;
    s_rdata = rd;
    #1;
    chk("rdy", 32'({m1_ready, m0_ready}), g ? 2 : 1);
    chk("rdata", g ? m1_rdata : m0_rdata, rd);
    chk("to_err", 32'(timeout_err), 0);
    cyc();
    s_ready = 1'b0;
    s_rdata = 32'h0;
    drop(g);
    #1;
    chk("idle_sv", 32'(s_valid), 0);
    chk("idle_rdy", 32'({m1_ready, m0_ready}), 0);
  endtask

  task automatic to_txn(input logic g);
    cyc(); #1;
    chk("to_grant", 32'(grant), 32'(g));
    chk("to_sv", 32'(s_valid), 1);
    for (int i = 0; i < T - 1; i++) begin
      chk("to_early", 32'({m1_ready, m0_ready}), 0);
      chk("to_early_err", 32'(timeout_err), 0);
      cyc(); #1;
    end
    #1;
    chk("to_rdy", 32'({m1_ready, m0_ready}), g ? 2 : 1);
    chk("to_rdata", g ? m1_rdata : m0_rdata, ERR);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_sv_low", 32'(s_valid), 0);
    cyc();
    drop(g);
    #1;
    chk("to_err_pulse", 32'(timeout_err), 0);
    chk("to_idle_sv", 32'(s_valid), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc(); #1;
    chk("rst_sv", 32'(s_valid), 0);
    chk("rst_rdy", 32'({m1_ready, m0_ready}), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_err", 32'(timeout_err), 0);
    reset = 1'b0;
  endtask

  task automatic driver(input logic i, input int n);
    for (int t = 0; t < n; t++) begin
      int w = 0;
      repeat ($urandom_range(0, 3)) cyc();
      if (i) begin
        m1_addr  = $urandom;
        m1_wdata = $urandom;
        m1_wstrb = $urandom_range(0, 1) ?
                   4'($urandom) : 4'h0;
        m1_valid = 1'b1;
      end else begin
        m0_addr  = $urandom;
        m0_wdata = $urandom;
        m0_wstrb = $urandom_range(0, 1) ?
                   4'($urandom) : 4'h0;
        m0_valid = 1'b1;
      end
      do begin
        @(negedge clk);
        w++;
      end while (!(i ? m1_ready : m0_ready) && w < 60);
      if (!(i ? m1_ready : m0_ready)) begin
        vec++;
        err++;
        $display("FAIL wait_rdy: m%0d got no ready want ready",
                 i);
      end
      cyc();
      drop(i);
    end
  endtask

  // Slave plus arbitration model: decides each response up front
  task automatic bus_model();
    logic        active = 1'b0;
    logic        last = 1'b1;
    logic        owner = 1'b0;
    logic        pv0 = 1'b0;
    logic        pv1 = 1'b0;
    logic        eg;
    logic [31:0] data = 32'h0;
    int          k = 0;
    int          n = 0;
    while (!rnd_stop) begin
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      exp_to  = 1'b0;
      #1;
      if (!active && s_valid) begin
        if (!pv0 && !pv1)
          chk("spurious", 32'(s_valid), 0);
        eg = (pv0 && pv1) ? !last : !pv0;
        chk("rr_grant", 32'(grant), 32'(eg));
        last   = eg;
        owner  = eg;
        active = 1'b1;
        n      = 0;
        k      = $urandom_range(1, T + 2);
        data   = $urandom;
        q.push_back('{g: eg,
                      d: (k <= T) ? data : ERR,
                      e: (k > T)});
      end
      if (active) begin
        n++;
        chk("rs_addr", s_addr, owner ? m1_addr : m0_addr);
        chk("rs_wdata", s_wdata,
            owner ? m1_wdata : m0_wdata);
        chk("rs_wstrb", 32'(s_wstrb),
            32'(owner ? m1_wstrb : m0_wstrb));
        if (n == k) begin
          s_ready = 1'b1;
          s_rdata = data;
          active  = 1'b0;
        end else if (n == T) begin
          exp_to = 1'b1;
          active = 1'b0;
        end
      end
      pv0 = m0_valid;
      pv1 = m1_valid;
    end
    s_ready = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    while (!rnd_stop) begin
      @(negedge clk);
      if (exp_to)
        chk("rto_sv", 32'(s_valid), 0);
      if (m0_ready && m1_ready) begin
        chk("both_rdy", 32'({m1_ready, m0_ready}), 1);
      end else if (m0_ready || m1_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexp", 32'({m1_ready, m0_ready}), 0);
        end else begin
          e = q.pop_front();
          chk("sb_master", 32'(m1_ready), 32'(e.g));
          chk("sb_rdata", m1_ready ? m1_rdata : m0_rdata,
              e.d);
          chk("sb_err", 32'(timeout_err), 32'(e.e));
        end
      end else begin
        chk("idle_rdata", m0_rdata | m1_rdata, 0);
        chk("idle_err", 32'(timeout_err), 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    #1;
    do_reset();
    // round-robin ties from reset
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    #1;
    txn(1'b0, 0, 32'h1111_0000);
    txn(1'b1, 0, 32'h2222_0000);
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    txn(1'b0, 1, 32'h3333_0000);
    txn(1'b1, 0, 32'h4444_0000);
    // single-master read
    m0_addr  = 32'h0300_0000;
    m0_wstrb = 4'h0;
    m0_valid = 1'b1;
    txn(1'b0, 2, 32'h1234_5678);
    // timeout
    m1_addr  = 32'h0200_0004;
    m1_valid = 1'b1;
    to_txn(1'b1);
    // s_ready in the timeout cycle
    m0_valid = 1'b1;
    txn(1'b0, T - 1, 32'hCAFE_F00D);
    // write from m1
    m1_wstrb = 4'b0011;
    m1_wdata = 32'hAABB_CCDD;
    m1_valid = 1'b1;
    txn(1'b1, 1, 32'h0);
    m0_valid = 1'b1;
    txn(1'b0, 0, 32'h5555_0000);
    // m1 drops valid mid-transaction
    m1_valid = 1'b1;
    cyc(); #1;
    chk("drop_grant", 32'(grant), 1);
    chk("drop_sv", 32'(s_valid), 1);
    m1_valid = 1'b0;
    #1;
    chk("drop_sv_low", 32'(s_valid), 0);
    chk("drop_rdy", 32'({m1_ready, m0_ready}), 0);
    cyc(); #1;
    chk("drop_idle_rdy", 32'({m1_ready, m0_ready}), 0);
    chk("drop_idle_sv", 32'(s_valid), 0);
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    txn(1'b0, 0, 32'h6666_0000);
    txn(1'b1, 0, 32'h7777_0000);
    m0_valid = 1'b1;
    txn(1'b0, 0, 32'h8888_0000);
    // reset while busy
    m0_valid = 1'b1;
    cyc(); #1;
    chk("rb_sv", 32'(s_valid), 1);
    reset   = 1'b1;
    s_ready = 1'b1;
    s_rdata = 32'h9999_0000;
    #1;
    chk("rb_rdy", 32'({m1_ready, m0_ready}), 0);
    chk("rb_sv_rst", 32'(s_valid), 0);
    cyc();
    reset    = 1'b0;
    s_ready  = 1'b0;
    m1_valid = 1'b1;
    #1;
    chk("rb_sv_after", 32'(s_valid), 0);
    chk("rb_rdy_after", 32'({m1_ready, m0_ready}), 0);
    txn(1'b0, 0, 32'hAAAA_0000);
    txn(1'b1, 0, 32'hBBBB_0000);
    // randomized traffic
    do_reset();
    fork
      begin
        fork
          driver(1'b0, 60);
          driver(1'b1, 60);
        join
        repeat (8) cyc();
        rnd_stop = 1'b1;
      end
      bus_model();
      monitor();
    join
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end

endmodule
